wide_add_sequencer: RTL and testbench

Multi-cycle controller that performs one WORDS×WIDTH-bit add or subtract by driving a single WIDTH-bit carry-lookahead adder slice-by-slice, least-significant slice first. The carry is registered between slices. It sits between the operand/command source and the shared CLA datapath, so wide arithmetic costs one narrow adder instead of a full-width one. It supplies a start/done handshake and registered wide result, carry and signed-overflow outputs.

---
 rtl/wide_add_sequencer_pkg.sv | 15 +
 rtl/wide_add_sequencer_cla.sv | 28 ++
 rtl/wide_add_sequencer.sv | 82 ++++++++
 tb/tb_wide_add_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// wide_add_sequencer_pkg: shared state encoding and sizing helpers for the wide add sequencer.
package wide_add_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WORDS = 4;
    localparam int DEF_IDX_W = $clog2(DEF_WORDS);

    function automatic int idx_w(input int words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction
endpackage

// File: rtl/wide_add_sequencer_cla.sv
// CLA_adder: single WIDTH-bit carry-lookahead slice with carry-out and signed overflow.
module CLA_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++)
            c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign sum      = p ^ c[WIDTH-1:0];
    assign cout     = c[WIDTH];
    assign overflow = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WORDS*WIDTH-bit add/subtract done one slice per cycle on one shared CLA slice.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [WIDTH*WORDS-1:0] A,
    input  logic [WIDTH*WORDS-1:0] B,
    input  logic                   Cin,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] Sum,
    output logic                   Cout,
    output logic                   overflow
);
    localparam int N  = WIDTH * WORDS;
    localparam int KW = idx_w(WORDS);

    state_t           state, state_nx;
    logic [N-1:0]     a_r, b_r;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] s;
    logic             co, ov, last, accept;

    CLA_adder #(.WIDTH(WIDTH)) u_cla (
        .a       (a_r[int'(k)*WIDTH +: WIDTH]),
        .b       (b_r[int'(k)*WIDTH +: WIDTH]),
        .cin     (carry),
        .sum     (s),
        .cout    (co),
        .overflow(ov)
    );

    assign last   = (k == KW'(WORDS - 1));
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        state_nx = state;
        if (state == RUN)
            state_nx = last ? DONE : RUN;
        else
            state_nx = accept ? RUN : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            k        <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // subtraction is A + ~B + 1, so Cin is dropped in sub mode
                a_r   <= A;
                b_r   <= sub ? ~B : B;
                carry <= sub | Cin;
                k     <= '0;
            end else if (state == RUN) begin
                Sum[int'(k)*WIDTH +: WIDTH] <= s;
                carry <= co;
                k     <= k + 1'b1;
                if (last) begin
                    Cout     <= co;
                    overflow <= ov;
                end
            end
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed self-checking bench for wide_add_sequencer (WIDTH=32, WORDS=4).
module tb_wide_add_sequencer;
    logic         clk = 1'b0;
    logic         rst_n, start, sub, Cin;
    logic [127:0] A, B;
    logic         busy, done, Cout, overflow;
    logic [127:0] Sum;
    int           checks = 0;
    int           failures = 0;
    int           n, dones;
    logic [127:0] xs [3];
    logic [127:0] ys [3];

    wide_add_sequencer #(.WIDTH(32), .WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // from the negedge after the accepting edge, count cycles until done shows up
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            check("busy_done_overlap", {127'd0, busy & done}, 128'd0);
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                          input logic c, input logic s, input logic [127:0] exp_sum,
                          input logic exp_cout, input logic exp_ov);
        A = a; B = b; Cin = c; sub = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; A = '1; B = '1; Cin = 1'b0; sub = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 128'(n), 128'd5);
        check({tag, "_sum"}, Sum, exp_sum);
        check({tag, "_cout"}, {127'd0, Cout}, {127'd0, exp_cout});
        check({tag, "_ovf"}, {127'd0, overflow}, {127'd0, exp_ov});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_sum", Sum, 128'd0);
        check("rst_cout_ovf", {126'd0, Cout, overflow}, 128'd0);

        run_op("ripple", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        run_op("borrow", 128'd0, 128'd1, 1'b0, 1'b1, {128{1'b1}}, 1'b0, 1'b0);
        run_op("sovf", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1);
        run_op("cin", 128'h1_0000_0000, 128'h2_FFFF_FFFF, 1'b1, 1'b0, 128'h4_0000_0000, 1'b0, 1'b0);
        run_op("subcin", 128'd100, 128'd30, 1'b1, 1'b1, 128'd70, 1'b1, 1'b0);

        // start pulses during RUN must be ignored
        A = 128'd10; B = 128'd20; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 1 || i == 2) begin
                start = 1'b1; A = 128'd999; B = 128'd1;
            end else
                start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("busy_start_dones", 128'(dones), 128'd1);
        check("busy_start_sum", Sum, 128'd30);

        xs[0] = 128'h1111_0000_0000_0000_FFFF_FFFF_0000_0001; ys[0] = 128'h0000_0000_0000_0001_0000_0001_0000_0002;
        xs[1] = 128'd5;                                       ys[1] = 128'd7;
        xs[2] = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};            ys[2] = 128'd1;
        start = 1'b1; sub = 1'b0; Cin = 1'b0; A = xs[0]; B = ys[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 2) begin
                A = xs[i+1]; B = ys[i+1];
            end else
                start = 1'b0;
            wait_done(n);
            check($sformatf("b2b%0d_latency", i), 128'(n), 128'd5);
            check($sformatf("b2b%0d_sum", i), Sum, xs[i] + ys[i]);
        end
        check("b2b2_sum_const", Sum, {63'd0, 1'b1, 64'd0});

        // reset in the cycle that processes slice 2
        A = {128{1'b1}}; B = 128'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_busy", {127'd0, busy}, 128'd0);
        check("mrst_done", {127'd0, done}, 128'd0);
        check("mrst_sum", Sum, 128'd0);
        check("mrst_cout_ovf", {126'd0, Cout, overflow}, 128'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("mrst_no_done", 128'(dones), 128'd0);
        run_op("after_rst", 128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 128'd0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
